// File: rtl/ripple_carry_adder_4bit_pkg.sv
// Shared arithmetic constants for the ripple-carry adder slice.
package ripple_carry_adder_4bit_pkg;

  localparam int unsigned ADDER_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_4bit_full_adder_1bit.sv
// Single-bit full-adder cell; purely combinational building block of the ripple chain.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_4bit.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained by carry, 1-cycle latency with valid flag.
module ripple_carry_adder_4bit
  import ripple_carry_adder_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;
  logic             cout_comb;
  logic             ovf_comb;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (s_comb[i]),
      .cout (c[i+1])
    );
  end

  assign cout_comb = c[WIDTH];
  assign ovf_comb  = c[WIDTH] ^ c[WIDTH-1];

  // Result registers only load on accepted operations, so unsampled inputs never disturb them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s_comb;
        cout     <= cout_comb;
        overflow <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Scoreboard bench for ripple_carry_adder_4bit: driver queues expected results, monitor checks each cycle.
module tb_ripple_carry_adder_4bit;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  exp_t q[$];
  exp_t held;
  int   total  = 0;
  int   passed = 0;

  ripple_carry_adder_4bit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: plain unsigned sum, and signed overflow as range violation of the signed sum.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    exp_t        e;
    int unsigned u;
    int          sx, sy, st;
    u  = int'(x) + int'(y) + int'(ci);
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    st = sx + sy + int'(ci);
    e.s = u[W-1:0];
    e.c = u[W];
    e.v = (st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)));
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic v);
    a = x; b = y; cin = ci; in_valid = v;
    @(posedge clock);
    if (!reset && v) q.push_back(model(x, y, ci));
    #1;
  endtask

  // Monitor: one cycle after each capture the queued result must be presented; otherwise outputs hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("sum", {60'd0, sum}, {60'd0, e.s});
        chk("cout", {63'd0, cout}, {63'd0, e.c});
        chk("overflow", {63'd0, overflow}, {63'd0, e.v});
        held = e;
      end else begin
        chk("hold_sum", {60'd0, sum}, {60'd0, held.s});
        chk("hold_cout", {63'd0, cout}, {63'd0, held.c});
        chk("hold_ovf", {63'd0, overflow}, {63'd0, held.v});
      end
    end
  end

  initial begin
    held = '{s: '0, c: 1'b0, v: 1'b0};
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {60'd0, sum}, 64'd0);
    reset = 1'b0;

    // Directed scenarios
    drive(4'b0001, 4'b0010, 1'b1, 1'b1);
    drive(4'b1111, 4'b0000, 1'b1, 1'b1);
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    drive(4'b0111, 4'b0001, 1'b0, 1'b1);
    drive(4'b0001, 4'b0010, 1'b1, 1'b1);
    repeat (3) drive('x, 'x, 'x, 1'b0);

    // Async reset between edges while a result is presented
    drive(4'b0001, 4'b0010, 1'b1, 1'b1);
    chk("pre_rst_sum", {60'd0, sum}, 64'd4);
    #2;
    reset = 1'b1;
    q.delete();
    held = '{s: '0, c: 1'b0, v: 1'b0};
    #1;
    chk("async_valid", {63'd0, out_valid}, 64'd0);
    chk("async_sum", {60'd0, sum}, 64'd0);
    chk("async_cout", {63'd0, cout}, 64'd0);
    chk("async_ovf", {63'd0, overflow}, 64'd0);
    in_valid = 1'b1; a = 4'b0011; b = 4'b0011; cin = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_no_capture", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    drive(4'b0011, 4'b0011, 1'b0, 1'b1);

    // Exhaustive, back-to-back
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      drive(v[3:0], v[7:4], v[8], 1'b1);
    end

    // Random operands with random valid gaps
    for (int i = 0; i < 300; i++)
      drive(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

    drive('0, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    chk("drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder_4bit.md
Name: ripple_carry_adder_4bit

Overview:
Width-parameterised ripple-carry adder, 4 bits by default. It is built from a chain of 1-bit full-adder cells and computes sum = a + b + cin. Operands are captured and the result is registered, so the block drops into a synchronous datapath with a fixed 1-cycle latency and a valid flag.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  a, b and cin are valid this cycle.
a  input  WIDTH  unsigned/two's-complement operand A.
b  input  WIDTH  operand B.
cin  input  1  carry into bit 0.
out_valid  output  1  sum/cout/overflow hold the result of an accepted operation.
sum  output  WIDTH  registered (a + b + cin) modulo 2^WIDTH.
cout  output  1  registered carry out of bit WIDTH-1.
overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset
  - Asserting reset, at any time and independent of clock, immediately forces sum=0, cout=0, overflow=0, out_valid=0.
  - Reset mid-operation discards any in-flight result.
  - The first capture is the first rising edge with reset low and in_valid=1.
- Datapath
  - Combinational ripple chain: c[0]=cin.
  - Each bit i: s[i]=a[i]^b[i]^c[i]; c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - Combinational cout=c[WIDTH]; combinational overflow=c[WIDTH]^c[WIDTH-1].
  - The chain is explicitly rippled: no carry-lookahead and no use of a behavioural "+" for the sum.
- Latency and handshake
  - On a rising edge with in_valid=1: sum, cout and overflow registers load the combinational results, and out_valid<=1.
  - On a rising edge with in_valid=0: out_valid<=0; sum, cout and overflow hold their previous values.
  - Result appears exactly 1 cycle after capture.
  - No backpressure; a new operand may be accepted every cycle (throughput 1/cycle).
- Arithmetic rules
  - Unsigned result is {cout,sum}, range 0..2^(WIDTH+1)-1.
  - The maximum case, all-ones + all-ones + cin=1, gives sum=all-ones and cout=1.
  - overflow is meaningful only for signed interpretation; it is always computed.
- X-handling: inputs are not sampled when in_valid=0, so X on a, b or cin at that time must not change the registered outputs.

Decomposition:
- No shared package is required.
- If the team keeps an arithmetic package, a WIDTH default constant (ADDER_WIDTH=4) may live there; otherwise the parameter is local.
- One sub-module, full_adder_1bit, with ports a, b, cin, sum, cout (purely combinational).
  - Instantiated WIDTH times via a generate loop.
  - Carry wires are chained c[i] -> c[i+1].
- The top level holds the generate chain, the overflow logic and the output/valid registers.

Test Plan:
1. Basic add: reset, then a=0001, b=0010, cin=1, in_valid=1 for one edge -> next cycle out_valid=1, sum=0100 (4), cout=0, overflow=0.
2. Full ripple: a=1111, b=0000, cin=1 -> sum=0000, cout=1, overflow=0; the carry propagates through all 4 cells.
3. Max and signed overflow:
   - a=1111, b=1111, cin=1 -> sum=1111, cout=1, overflow=0.
   - a=0111, b=0001, cin=0 -> sum=1000, cout=0, overflow=1.
4. Hold and valid:
   - After scenario 1, drop in_valid and drive a=X, b=X for 3 cycles -> out_valid=0 each cycle, sum stays 0100, cout stays 0.
   - Back-to-back valid operands on consecutive cycles each produce a result exactly one cycle later.
5. Async reset:
   - With out_valid=1 and sum=0100, assert reset between clock edges -> sum, cout, overflow and out_valid go to 0 before the next edge.
   - With in_valid=1 held during reset, no capture occurs until the first edge after reset deasserts.
6. Exhaustive: all 512 combinations of a, b, cin at WIDTH=4, fed one per cycle -> each {cout,sum} equals a+b+cin, and each overflow matches the signed rule.
